vram_arbiter: RTL and testbench

- Shares the single read port of the VGA VRAM dpram between two requesters: the pixel-fetch pipeline (video) and the CPU MMIO bus.
- Also owns the dpram write port for CPU writes, including byte-strobe merging by read-modify-write (RMW).
- Sits between the vga MMIO decode and the nvram/fontram dpram instances, all on the pixel clock.
- Video has strict priority; CPU accesses stall until the read port is free.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vram_arbiter_if.sv | 23 ++
 rtl/vram_arbiter.sv | 122 ++++++++++++
 tb/tb_vram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types: arbiter FSM states, default VRAM geometry and the byte-merge helper.
// RMW states exist only when VRAM_ARBITER_RMW_EN is defined.
package vga_pkg;

  localparam int VRAM_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
`ifdef VRAM_ARBITER_RMW_EN
    RMW_REQ  = 3'd3,
    RMW_WAIT = 3'd4,
`endif
    WRITE    = 3'd5,
    RESP     = 3'd6,
    HOLD     = 3'd7
  } arb_state_e;

  // Strobed bytes come from new_w, the rest from old_w.
  function automatic logic [15:0] merge16(input logic [15:0] old_w,
                                          input logic [15:0] new_w,
                                          input logic [1:0]  strb);
    merge16 = {strb[1] ? new_w[15:8] : old_w[15:8],
               strb[0] ? new_w[7:0]  : old_w[7:0]};
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU MMIO bus seen by the VRAM arbiter: request/strobe/address/data in, read data and ready out.
interface vram_arbiter_if import vga_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W
) ();

  logic              bus_sel;
  logic [3:0]        bus_wstrb;
  logic [ADDR_W+1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ready;

  modport master (
    output bus_sel, bus_wstrb, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_sel, bus_wstrb, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/vram_arbiter.sv
// VRAM read-port arbiter (video has strict priority over CPU) and CPU write path.
// Define VRAM_ARBITER_RMW_EN to merge partial byte strobes by read-modify-write.
module vram_arbiter import vga_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  vram_arbiter_if.slave     bus,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata
);

  arb_state_e  state_q, state_d;
  logic        cpu_rd;
  logic        ready_c;
  logic [31:0] rdata_q;
`ifdef VRAM_ARBITER_RMW_EN
  logic [1:0]  strb_q;
`endif

  // Address LSBs and upper write-data half are not part of the 16-bit word path.
  logic unused_bits;
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:16]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cpu_rd  = 1'b0;
    ram_wen = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bus_sel) begin
          if (bus.bus_wstrb[1:0] == 2'b00)
            state_d = (bus.bus_wstrb[3:2] == 2'b00) ? RD_REQ : RESP;
`ifdef VRAM_ARBITER_RMW_EN
          else if (bus.bus_wstrb[1:0] != 2'b11)
            state_d = RMW_REQ;
`endif
          else
            state_d = WRITE;
        end
      end
      RD_REQ: begin
        cpu_rd = 1'b1;
        if (!bus.bus_sel)  state_d = IDLE;
        else if (!vid_req) state_d = RD_WAIT;
      end
      RD_WAIT: state_d = bus.bus_sel ? RESP : IDLE;
`ifdef VRAM_ARBITER_RMW_EN
      RMW_REQ: begin
        cpu_rd = 1'b1;
        if (!bus.bus_sel)  state_d = IDLE;
        else if (!vid_req) state_d = RMW_WAIT;
      end
      RMW_WAIT: state_d = bus.bus_sel ? WRITE : IDLE;
`endif
      WRITE: begin
        ram_wen = 1'b1;
        ready_c = 1'b1;
        state_d = HOLD;
      end
      RESP: begin
        ready_c = 1'b1;
        state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Video always owns the read port when it asks; the CPU only gets idle cycles.
  assign ram_ren   = vid_req | cpu_rd;
  assign ram_raddr = vid_req ? vid_addr : ram_waddr;
  assign vid_data  = ram_rdata;

  assign bus.bus_ready = ready_c;
  assign bus.bus_rdata = rdata_q;

  // ram_waddr doubles as the latched CPU word address for the read mux.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vid_valid <= 1'b0;
      rdata_q   <= '0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      vid_valid <= vid_req;
      if (state_q == IDLE && bus.bus_sel) begin
        ram_waddr <= bus.bus_addr[ADDR_W+1:2];
        ram_wdata <= merge16(16'h0000, bus.bus_wdata[15:0], bus.bus_wstrb[1:0]);
      end
      if (state_q == RD_WAIT && bus.bus_sel)
        rdata_q <= {{(32-DATA_W){1'b0}}, ram_rdata};
`ifdef VRAM_ARBITER_RMW_EN
      if (state_q == RMW_WAIT && bus.bus_sel)
        ram_wdata <= merge16(ram_rdata, ram_wdata, strb_q);
`endif
    end
  end

`ifdef VRAM_ARBITER_RMW_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            strb_q <= 2'b00;
    else if (state_q == IDLE && bus.bus_sel) strb_q <= bus.bus_wstrb[1:0];
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: test-plan vectors, reset/abort sequences and random traffic vs a rule model.
module tb_vram_arbiter;

  localparam int AW = 12;
`ifdef VRAM_ARBITER_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [15:0]   vid_data;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [15:0]   ram_rdata;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;

  vram_arbiter_if #(.ADDR_W(AW)) bus_if ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_valid (vid_valid),
    .vid_data  (vid_data),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment dpram: registered read, read-before-write on collision.
  logic [15:0] ram [4096];
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= ram[ram_raddr];
    if (ram_wen) ram[ram_waddr] <= ram_wdata;
  end

  // Reference state
  logic [15:0] model_mem [4096];
  bit          prev_vid;
  logic [15:0] prev_vdata;
  logic [31:0] last_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One CPU transaction, cycle by cycle, with all outputs checked against the rule model.
  task automatic run_txn(input logic [3:0] strb, input logic [13:0] baddr, input logic [15:0] wd,
                         input logic [15:0] vpat, input bit rnd_va,
                         output int lat, output logic [31:0] rd_o, output logic [15:0] wr_o);
    logic [11:0] word, va;
    logic [15:0] oldv, newv;
    bit is_rd, is_rsv, is_wr, needs_port, granted, v, cpu_want, done;
    int ready_at;
    word       = baddr[13:2];
    is_rd      = (strb == 4'b0000);
    is_rsv     = (strb[1:0] == 2'b00) && (strb[3:2] != 2'b00);
    is_wr      = (strb[1:0] != 2'b00);
    needs_port = is_rd || (RMW && (strb[1:0] == 2'b01 || strb[1:0] == 2'b10));
    ready_at   = needs_port ? -1 : 1;
    granted = 1'b0; done = 1'b0; lat = -1; rd_o = '0; wr_o = '0; newv = '0;
    for (int rel = 0; rel <= 40 && !done; rel++) begin
      v        = (rel < 16) ? vpat[rel[3:0]] : 1'b0;
      va       = rnd_va ? 12'($urandom_range(0, 15)) : 12'(32'h100 + rel);
      cpu_want = needs_port && !granted && rel >= 1;
      vid_req  = v;
      vid_addr = va;
      bus_if.bus_sel   = (ready_at < 0) || (rel <= ready_at);
      bus_if.bus_wstrb = strb;
      bus_if.bus_addr  = baddr;
      bus_if.bus_wdata = {16'hDEAD, wd};
      @(negedge clk);
      chk("vid_valid", 32'(vid_valid), 32'(prev_vid));
      if (prev_vid) chk("vid_data", 32'(vid_data), 32'(prev_vdata));
      chk("ram_ren", 32'(ram_ren), 32'(v | cpu_want));
      if (v)             chk("ram_raddr_vid", 32'(ram_raddr), 32'(va));
      else if (cpu_want) chk("ram_raddr_cpu", 32'(ram_raddr), 32'(word));
      if (cpu_want && !v) begin
        granted  = 1'b1;
        ready_at = rel + 2;
      end
      chk("bus_ready", 32'(bus_if.bus_ready), 32'(rel == ready_at));
      chk("ram_wen", 32'(ram_wen), 32'(is_wr && rel == ready_at));
      if (rel == ready_at) begin
        lat  = rel;
        rd_o = bus_if.bus_rdata;
        if (is_rd)  chk("bus_rdata", bus_if.bus_rdata, {16'h0, model_mem[word]});
        if (is_rsv) chk("bus_rdata_rsv", bus_if.bus_rdata, last_rdata);
        if (is_wr) begin
          oldv = RMW ? model_mem[word] : 16'h0000;
          newv = {strb[1] ? wd[15:8] : oldv[15:8], strb[0] ? wd[7:0] : oldv[7:0]};
          chk("ram_waddr", 32'(ram_waddr), 32'(word));
          chk("ram_wdata", 32'(ram_wdata), 32'(newv));
          wr_o = ram_wdata;
        end
      end
      prev_vid = v;
      if (v) prev_vdata = model_mem[va];
      if (is_wr && rel == ready_at) model_mem[word] = newv;
      if (is_rd && rel == ready_at) last_rdata = {16'h0, model_mem[word]};
      @(posedge clk); #1;
      if (ready_at >= 0 && rel == ready_at + 1) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL txn_timeout: got no ready, expected ready at %0d", ready_at);
    end
  endtask

  typedef struct {
    logic [3:0]  strb;
    logic [13:0] baddr;
    logic [15:0] wd;
    logic [15:0] vpat;
    int          exp_lat;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          chk_wr;
    logic [15:0] exp_wr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [15:0] wr;
    logic [15:0] init_v;

    vecs[0] = '{4'b0011, 14'h0010, 16'hBEEF, 16'h0000, 1, 1'b0, 32'h0, 1'b1, 16'hBEEF};
    vecs[1] = '{4'b0000, 14'h0010, 16'h0000, 16'h0000, 3, 1'b1, 32'h0000_BEEF, 1'b0, 16'h0};
    vecs[2] = '{4'b0000, 14'h0010, 16'h0000, 16'h001F, 7, 1'b1, 32'h0000_BEEF, 1'b0, 16'h0};
    vecs[3] = '{4'b0010, 14'h0010, 16'h1200, 16'h0000, RMW ? 3 : 1, 1'b0, 32'h0, 1'b1,
                RMW ? 16'h12EF : 16'h1200};
    vecs[4] = '{4'b0000, 14'h0010, 16'h0000, 16'h0000, 3, 1'b1,
                RMW ? 32'h0000_12EF : 32'h0000_1200, 1'b0, 16'h0};
    vecs[5] = '{4'b0100, 14'h0010, 16'hFFFF, 16'h0000, 1, 1'b1,
                RMW ? 32'h0000_12EF : 32'h0000_1200, 1'b0, 16'h0};
    vecs[6] = '{4'b0011, 14'h0020, 16'hA5A5, 16'h0000, 1, 1'b0, 32'h0, 1'b1, 16'hA5A5};
    vecs[7] = '{4'b0001, 14'h0020, 16'h0033, 16'h0002, RMW ? 4 : 1, 1'b0, 32'h0, 1'b1,
                RMW ? 16'hA533 : 16'h0033};
    vecs[8] = '{4'b0000, 14'h0020, 16'h0000, 16'h0006, 5, 1'b1,
                RMW ? 32'h0000_A533 : 32'h0000_0033, 1'b0, 16'h0};
    vecs[9] = '{4'b0000, 14'h0023, 16'h0000, 16'h0001, 3, 1'b1,
                RMW ? 32'h0000_A533 : 32'h0000_0033, 1'b0, 16'h0};

    for (int i = 0; i < 4096; i++) begin
      init_v       = 16'($urandom);
      ram[i]      <= init_v;
      model_mem[i] = init_v;
    end
    resetn = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    bus_if.bus_sel = 1'b0; bus_if.bus_wstrb = '0; bus_if.bus_addr = '0; bus_if.bus_wdata = '0;
    prev_vid = 1'b0; prev_vdata = '0; last_rdata = '0;

    @(negedge clk);
    chk("reset_bus_ready", 32'(bus_if.bus_ready), 32'h0);
    chk("reset_bus_rdata", bus_if.bus_rdata, 32'h0);
    chk("reset_vid_valid", 32'(vid_valid), 32'h0);
    chk("reset_ram_wen", 32'(ram_wen), 32'h0);
    chk("reset_ram_waddr", 32'(ram_waddr), 32'h0);
    chk("reset_ram_wdata", 32'(ram_wdata), 32'h0);
    chk("reset_ram_ren", 32'(ram_ren), 32'h0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].strb, vecs[i].baddr, vecs[i].wd, vecs[i].vpat, 1'b0, lat, rd, wr);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].chk_wr) chk($sformatf("vec%0d_wdata", i), 32'(wr), 32'(vecs[i].exp_wr));
    end

    // Async reset in the wait state of a partial write (RMW build) or a read (plain build).
    bus_if.bus_sel   = 1'b1;
    bus_if.bus_wstrb = RMW ? 4'b0001 : 4'b0000;
    bus_if.bus_addr  = 14'h0010;
    bus_if.bus_wdata = 32'h0000_0055;
    vid_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_ready", 32'(bus_if.bus_ready), 32'h0);
    chk("async_rst_wen", 32'(ram_wen), 32'h0);
    chk("async_rst_rdata", bus_if.bus_rdata, 32'h0);
    bus_if.bus_sel = 1'b0;
    @(negedge clk);
    chk("async_rst_hold_wen", 32'(ram_wen), 32'h0);
    chk("async_rst_hold_ready", 32'(bus_if.bus_ready), 32'h0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(bus_if.bus_ready), 32'h0);
      chk("post_rst_wen", 32'(ram_wen), 32'h0);
      chk("post_rst_ren", 32'(ram_ren), 32'h0);
      @(posedge clk); #1;
    end
    prev_vid = 1'b0; last_rdata = '0;
    run_txn(4'b0000, 14'h0010, 16'h0000, 16'h0000, 1'b0, lat, rd, wr);
    chk("post_rst_read_latency", 32'(lat), 32'd3);
    chk("post_rst_read_data", rd, RMW ? 32'h0000_12EF : 32'h0000_1200);

    // Master drops bus_sel while the read is still stalled behind video.
    bus_if.bus_wstrb = 4'b0000;
    bus_if.bus_addr  = 14'h0020;
    vid_addr         = 12'h200;
    for (int k = 0; k < 7; k++) begin
      vid_req        = (k < 4);
      bus_if.bus_sel = (k < 2);
      @(negedge clk);
      chk("drop_ready", 32'(bus_if.bus_ready), 32'h0);
      chk("drop_wen", 32'(ram_wen), 32'h0);
      if (k >= 4) chk("drop_ren", 32'(ram_ren), 32'h0);
      @(posedge clk); #1;
    end
    prev_vid = 1'b0;
    run_txn(4'b0000, 14'h0020, 16'h0000, 16'h0000, 1'b0, lat, rd, wr);
    chk("post_drop_latency", 32'(lat), 32'd3);

    for (int t = 0; t < 80; t++) begin
      logic [3:0] s;
      case ($urandom_range(0, 5))
        0:       s = 4'b0000;
        1:       s = 4'b0011;
        2:       s = 4'b0001;
        3:       s = 4'b0010;
        4:       s = 4'b1000;
        default: s = 4'b0000;
      endcase
      run_txn(s, {12'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, 16'($urandom),
              16'($urandom & $urandom), 1'b1, lat, rd, wr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
